// File: rtl/structure1_pkg.sv
// structure1 shared types and constants.
// Used by the FC2 output stage and the MAC array.
package structure1_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ADD,
    ST_SAT,
    ST_DONE
  } fc2_state_e;

  localparam logic signed [7:0] INT8_MAX = 8'sh7f;
  localparam logic signed [7:0] INT8_MIN = 8'sh80;

  localparam int FC2_NUM_OUT    = 10;
  localparam int FC2_ACC_W      = 24;
  localparam int FC2_BIAS_SHIFT = 4;
  localparam int FC2_OUT_SHIFT  = 8;

endpackage

// File: rtl/structure1_requant_sat.sv
// Round half-up, arithmetic shift right, clamp to int8.
// Purely combinational; shared by the requant stages.
module structure1_requant_sat
  import structure1_pkg::*;
#(
  parameter int IN_W      = 25,
  parameter int OUT_SHIFT = 8
) (
  input  logic signed [IN_W-1:0] sum_i,
  output logic signed [7:0]      q_o
);

  localparam int RW = IN_W + 1;

  localparam logic signed [RW-1:0] HALF =
    RW'(1) << (OUT_SHIFT - 1);
  localparam logic signed [RW-1:0] HI = RW'(INT8_MAX);
  localparam logic signed [RW-1:0] LO = RW'(INT8_MIN);

  logic signed [RW-1:0] rnd;
  logic signed [RW-1:0] shr;

  // One guard bit keeps the rounding add from wrapping.
  always_comb begin
    rnd = RW'(sum_i) + HALF;
    shr = rnd >>> OUT_SHIFT;
    if (shr > HI) begin
      q_o = INT8_MAX;
    end else if (shr < LO) begin
      q_o = INT8_MIN;
    end else begin
      q_o = shr[7:0];
    end
  end

endmodule

// File: rtl/structure1_fc2_bias_add.sv
// FC2 output stage: bias add, requant to int8,
// running argmax and per-frame class report.
module structure1_fc2_bias_add
  import structure1_pkg::*;
#(
  parameter int NUM_OUT    = FC2_NUM_OUT,
  parameter int ACC_W      = FC2_ACC_W,
  parameter int BIAS_SHIFT = FC2_BIAS_SHIFT,
  parameter int OUT_SHIFT  = FC2_OUT_SHIFT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    acc_valid_i,
  input  logic signed [ACC_W-1:0] acc_data_i,
  output logic                    acc_ready_o,
  output logic                    bias_en_o,
  input  logic signed [7:0]       bias_data_i,
  output logic                    out_valid_o,
  output logic signed [7:0]       out_data_o,
  output logic [3:0]              out_idx_o,
  output logic                    done_o,
  output logic [3:0]              class_idx_o
);

  localparam int SW = ACC_W + 1;
  localparam logic [3:0] LAST = 4'(NUM_OUT - 1);

  fc2_state_e state_q, state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [SW-1:0]    sum_c;
  logic signed [7:0]       q_c;
  logic [3:0]              cnt_q;
  logic signed [7:0]       best_val_q;
  logic [3:0]              best_idx_q;
  logic signed [7:0]       out_data_q;
  logic [3:0]              out_idx_q;
  logic                    out_valid_q;
  logic                    done_q;
  logic [3:0]              class_idx_q;
  logic                    upd_best;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (acc_valid_i) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_ADD;
      ST_ADD:   state_d = ST_SAT;
      ST_SAT:   state_d = (cnt_q == LAST) ? ST_DONE
                                          : ST_IDLE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign acc_ready_o = (state_q == ST_IDLE);
  assign bias_en_o   = (state_q == ST_FETCH);

  // Bias arrives the cycle after the FETCH pulse.
  assign sum_c = SW'(acc_q)
               + (SW'(bias_data_i) <<< BIAS_SHIFT);

  structure1_requant_sat #(
    .IN_W      (SW),
    .OUT_SHIFT (OUT_SHIFT)
  ) u_requant (
    .sum_i (sum_c),
    .q_o   (q_c)
  );

  // Neuron 0 seeds the argmax; later ties keep the lower index.
  assign upd_best = (cnt_q == 4'd0)
                 || (out_data_q > best_val_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      best_val_q  <= INT8_MIN;
      best_idx_q  <= '0;
      out_data_q  <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      class_idx_q <= '0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (acc_valid_i) acc_q <= acc_data_i;
        end
        ST_ADD: begin
          out_data_q  <= q_c;
          out_idx_q   <= cnt_q;
          out_valid_q <= 1'b1;
        end
        ST_SAT: begin
          if (upd_best) begin
            best_val_q <= out_data_q;
            best_idx_q <= cnt_q;
          end
          if (cnt_q == LAST) begin
            done_q      <= 1'b1;
            class_idx_q <= upd_best ? cnt_q : best_idx_q;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_idx_o   = out_idx_q;
  assign done_o      = done_q;
  assign class_idx_o = class_idx_q;

endmodule

// File: tb/tb_structure1_fc2_bias_add.sv
// Bench for structure1_fc2_bias_add with a bias ROM model
// and an arithmetic reference for requant and argmax.
module tb_structure1_fc2_bias_add;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              acc_valid;
  logic signed [23:0] acc_data;
  logic              acc_ready;
  logic              bias_en;
  logic signed [7:0] bias_data;
  logic              out_valid;
  logic signed [7:0] out_data;
  logic [3:0]        out_idx;
  logic              done;
  logic [3:0]        class_idx;

  always #5 clk = ~clk;

  structure1_fc2_bias_add dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .acc_valid_i (acc_valid),
    .acc_data_i  (acc_data),
    .acc_ready_o (acc_ready),
    .bias_en_o   (bias_en),
    .bias_data_i (bias_data),
    .out_valid_o (out_valid),
    .out_data_o  (out_data),
    .out_idx_o   (out_idx),
    .done_o      (done),
    .class_idx_o (class_idx)
  );

  logic signed [7:0] rom [16];
  logic [3:0]        rom_addr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      bias_data <= '0;
    end else if (bias_en) begin
      bias_data <= rom[rom_addr];
      rom_addr  <= rom_addr + 4'd1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_acc    = 0;
  int n_bias   = 0;
  int n_done   = 0;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (acc_valid && acc_ready) n_acc++;
      if (bias_en) n_bias++;
      if (done) n_done++;
    end
  end

  function automatic int model_q(input int acc, input int bias);
    int s;
    int r;
    s = acc + bias * 16 + 128;
    if (s >= 0) r = s / 256;
    else r = -((-s + 255) / 256);
    if (r > 127) r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  function automatic int model_argmax(input int q[10]);
    int b;
    b = 0;
    for (int i = 1; i < 10; i++) if (q[i] > q[b]) b = i;
    return b;
  endfunction

  function automatic int rnd_acc();
    return int'($urandom_range(0, 'h30000)) - 'h18000;
  endfunction

  function automatic int rnd_bias();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic do_reset();
    acc_valid = 1'b0;
    acc_data  = '0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_acc = 0; n_bias = 0; n_done = 0;
    @(posedge clk); #1;
  endtask

  task automatic run_neuron(input int idx, input int acc,
                            input int expq, input bit last,
                            input int expcls, input bit hold,
                            input int next_acc);
    int w;
    logic [7:0] eq;
    logic [3:0] ei;
    logic [3:0] ec;
    eq = expq[7:0];
    ei = idx[3:0];
    ec = expcls[3:0];
    w = 0;
    while (acc_ready !== 1'b1 && w < 20) begin
      @(posedge clk); #1; w++;
    end
    n_checks++;
    if (acc_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_wait idx=%0d acc_ready=%b want 1",
               idx, acc_ready);
    end
    acc_valid = 1'b1;
    acc_data  = 24'(acc);
    @(posedge clk); #1;
    n_checks++;
    if (bias_en !== 1'b1 || acc_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cyc1 idx=%0d bias_en=%b acc_ready=%b want 1/0",
               idx, bias_en, acc_ready);
    end
    if (hold) acc_data = 24'(next_acc);
    else acc_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bias_en !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cyc2 idx=%0d bias_en=%b out_valid=%b want 0/0",
               idx, bias_en, out_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== eq || out_idx !== ei) begin
      n_fail++;
      $display("FAIL out idx=%0d got v=%b d=%0d i=%0d want 1 %0d %0d",
               idx, out_valid, out_data, out_idx, expq, idx);
    end
    @(posedge clk); #1;
    if (last) begin
      n_checks++;
      if (done !== 1'b1 || class_idx !== ec || acc_ready !== 1'b0
          || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL done got d=%b c=%0d r=%b v=%b want 1 %0d 0 0",
                 done, class_idx, acc_ready, out_valid, expcls);
      end
      @(posedge clk); #1;
      n_checks++;
      if (done !== 1'b0 || acc_ready !== 1'b1 || class_idx !== ec) begin
        n_fail++;
        $display("FAIL post_done got d=%b r=%b c=%0d want 0 1 %0d",
                 done, acc_ready, class_idx, expcls);
      end
    end else begin
      n_checks++;
      if (acc_ready !== 1'b1 || out_valid !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL cyc4 idx=%0d r=%b v=%b d=%b want 1 0 0",
                 idx, acc_ready, out_valid, done);
      end
    end
  endtask

  task automatic run_frame(input int accs[10], input int bias[10],
                           input bit hold, input string name);
    int q[10];
    int cls;
    for (int i = 0; i < 10; i++) begin
      rom[i] = 8'(bias[i]);
      q[i]   = model_q(accs[i], bias[i]);
    end
    cls = model_argmax(q);
    do_reset();
    for (int i = 0; i < 10; i++) begin
      run_neuron(i, accs[i], q[i], i == 9, cls,
                 hold && (i < 9), (i < 9) ? accs[(i + 1) % 10] : 0);
    end
    n_checks++;
    if (n_bias !== 10 || n_done !== 1 || n_acc !== 10) begin
      n_fail++;
      $display("FAIL %s counts bias=%0d done=%0d acc=%0d want 10 1 10",
               name, n_bias, n_done, n_acc);
    end
  endtask

  task automatic test_reset();
    rom[0] = 8'sd0;
    do_reset();
    n_checks++;
    if (acc_ready !== 1'b1 || bias_en !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hs r=%b b=%b want 1 0", acc_ready, bias_en);
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== 8'd0 || out_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_out v=%b d=%0d i=%0d want 0 0 0",
               out_valid, out_data, out_idx);
    end
    n_checks++;
    if (done !== 1'b0 || class_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_cls d=%b c=%0d want 0 0", done, class_idx);
    end
  endtask

  task automatic test_single();
    rom[0] = 8'sd2;
    do_reset();
    run_neuron(0, 'h300, 3, 1'b0, 0, 1'b0, 0);
    n_checks++;
    if (n_bias !== 1 || n_acc !== 1) begin
      n_fail++;
      $display("FAIL single_pulse bias=%0d acc=%0d want 1 1",
               n_bias, n_acc);
    end
  endtask

  task automatic test_saturation();
    int a [12] = '{'h7F0000, -'h7F0000, 'h7F80, -'h8080,
                   127 * 256, -128 * 256, -129 * 256, 128 * 256,
                   -128, -129, 0, 'h7FFFFF};
    int b [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -128, 127};
    int e [12] = '{127, -128, 127, -128, 127, -128, -128, 127,
                   0, -1, -8, 127};
    for (int i = 0; i < 12; i++) begin
      rom[0] = 8'(b[i]);
      do_reset();
      run_neuron(0, a[i], e[i], 1'b0, 0, 1'b0, 0);
    end
    rom[0] = -8'sd128;
    do_reset();
    run_neuron(0, -'h800000, -128, 1'b0, 0, 1'b0, 0);
  endtask

  task automatic test_full_frame();
    int v [10] = '{5, -3, 9, 9, 0, -7, 8, 1, 9, -128};
    int a [10];
    int z [10];
    for (int i = 0; i < 10; i++) begin
      a[i] = v[i] * 256;
      z[i] = 0;
    end
    run_frame(a, z, 1'b0, "full_frame");
  endtask

  task automatic test_back_to_back();
    int a [10];
    int b [10];
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 10; i++) begin
        a[i] = rnd_acc();
        b[i] = rnd_bias();
      end
      run_frame(a, b, 1'b1, "back_to_back");
    end
  endtask

  task automatic test_random_frames();
    int a [10];
    int b [10];
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 10; i++) begin
        a[i] = rnd_acc();
        b[i] = rnd_bias();
      end
      run_frame(a, b, 1'($urandom_range(0, 1)), "random_frame");
    end
  endtask

  task automatic test_reset_midframe();
    int a [10];
    int b [10];
    for (int i = 0; i < 10; i++) begin
      a[i] = rnd_acc();
      b[i] = rnd_bias();
      rom[i] = 8'(b[i]);
    end
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_neuron(i, a[i], model_q(a[i], b[i]), 1'b0, 0, 1'b0, 0);
    end
    rst_n = 1'b0;
    #2;
    n_checks++;
    if (acc_ready !== 1'b1 || bias_en !== 1'b0 || out_valid !== 1'b0
        || out_data !== 8'd0 || out_idx !== 4'd0 || done !== 1'b0
        || class_idx !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_reset r=%b b=%b v=%b d=%0d i=%0d dn=%b c=%0d",
               acc_ready, bias_en, out_valid, out_data, out_idx,
               done, class_idx);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    n_checks++;
    if (n_done !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_done got %0d want 0", n_done);
    end
    run_frame(a, b, 1'b0, "after_reset");
  endtask

  task automatic test_all_negative();
    int a [10];
    int b [10];
    for (int i = 0; i < 10; i++) begin
      a[i] = -'h10000;
      b[i] = rnd_bias();
    end
    run_frame(a, b, 1'b0, "all_negative");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    for (int i = 0; i < 16; i++) rom[i] = '0;
    #1;
    test_reset();
    test_single();
    test_saturation();
    test_full_frame();
    test_back_to_back();
    test_random_frames();
    test_reset_midframe();
    test_all_negative();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
